note_sequencer: RTL

- Downstream consumer of CPU memory-mapped audio writes. The wrapper strobes a note command when the CPU stores to address 0x1002 (`mwe` asserted).
- Buffers note commands in a small FIFO, then plays them back-to-back as square-wave tones or rests of programmed duration.
- Drives the board audio pin directly, so software can queue a melody and continue running.

---
 rtl/note_seq_pkg.sv | 27 ++
 rtl/note_fifo.sv | 81 ++++++++
 rtl/note_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: command word layout, FSM states, MMIO address.
`timescale 1ns/1ps
package note_seq_pkg;

   localparam int CMD_W   = 32;
   localparam int HP_LSB  = 0;
   localparam int HP_W    = 20;
   localparam int DUR_LSB = 20;
   localparam int DUR_W   = 12;

   localparam logic [31:0] AUDIO_ADDR = 32'h1002;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2
   } state_t;

   function automatic logic [HP_W-1:0] cmd_hp(input logic [CMD_W-1:0] cmd);
      return cmd[HP_LSB +: HP_W];
   endfunction

   function automatic logic [DUR_W-1:0] cmd_dur(input logic [CMD_W-1:0] cmd);
      return cmd[DUR_LSB +: DUR_W];
   endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO for note commands: registered write, combinational head read,
// count-decoded full/empty, synchronous clear with priority over push/pop.
`timescale 1ns/1ps
module note_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_q == CNT_MAX);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         // Power-of-two depth: pointers wrap naturally at their width.
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Queues CPU note commands and plays them as square-wave tones or rests on audio_out.
// Optional NOTE_SEQ_FLUSH_EN adds a synchronous `flush` input that empties the queue and stops playback.
`timescale 1ns/1ps
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_HZ     = 50000000,
   parameter int TICK_HZ    = 1000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [31:0]                   note_data,
   input  logic                          note_valid,
`ifdef NOTE_SEQ_FLUSH_EN
   input  logic                          flush,
`endif
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic                          busy,
   output logic                          overflow,
   output logic                          audio_out,
   output state_t                        dbg_state,
   output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

   localparam int DIV   = CLK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

   state_t             state_q, state_d;
   logic [HP_W-1:0]    hp_q, hp_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [HP_W-1:0]    hp_cnt_q, hp_cnt_d;
   logic [DUR_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic               audio_q, audio_d;
   logic               ovf_q, ovf_d;

   logic               flush_w;
   logic               push;
   logic               pop;
   logic [CMD_W-1:0]   head;
   logic [DUR_W-1:0]   tick_inc;

`ifdef NOTE_SEQ_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // A write arriving while full is lost even if the head pops this cycle.
   assign push = note_valid & ~fifo_full & ~flush_w;

   note_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush_w),
      .push    (push),
      .pop     (pop),
      .wr_data (note_data),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (dbg_count)
   );

   assign tick_inc = tick_cnt_q + DUR_ONE;

   always_comb begin
      state_d    = state_q;
      hp_d       = hp_q;
      dur_d      = dur_q;
      hp_cnt_d   = hp_cnt_q;
      tick_cnt_d = tick_cnt_q;
      pre_d      = pre_q;
      audio_d    = audio_q;
      ovf_d      = ovf_q | (note_valid & fifo_full & ~flush_w);
      pop        = 1'b0;

      if (flush_w) begin
         state_d    = IDLE;
         audio_d    = 1'b0;
         hp_cnt_d   = '0;
         tick_cnt_d = '0;
         pre_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               audio_d = 1'b0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  hp_d    = cmd_hp(head);
                  dur_d   = cmd_dur(head);
                  state_d = LOAD;
               end
            end
            LOAD: begin
               hp_cnt_d   = '0;
               tick_cnt_d = '0;
               pre_d      = '0;
               if (dur_q == '0) begin
                  state_d = IDLE;
               end else begin
                  audio_d = (hp_q != '0);
                  state_d = PLAY;
               end
            end
            PLAY: begin
               if (hp_q == '0) begin
                  audio_d = 1'b0;
               end else if (hp_cnt_q == hp_q - HP_ONE) begin
                  hp_cnt_d = '0;
                  audio_d  = ~audio_q;
               end else begin
                  hp_cnt_d = hp_cnt_q + HP_ONE;
               end
               // Note end overrides any toggle landing on the same cycle.
               if (pre_q == PRE_LAST) begin
                  pre_d      = '0;
                  tick_cnt_d = tick_inc;
                  if (tick_inc == dur_q) begin
                     audio_d = 1'b0;
                     state_d = IDLE;
                  end
               end else begin
                  pre_d = pre_q + PRE_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               audio_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         hp_q       <= '0;
         dur_q      <= '0;
         hp_cnt_q   <= '0;
         tick_cnt_q <= '0;
         pre_q      <= '0;
         audio_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hp_q       <= hp_d;
         dur_q      <= dur_d;
         hp_cnt_q   <= hp_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         pre_q      <= pre_d;
         audio_q    <= audio_d;
         ovf_q      <= ovf_d;
      end
   end

   assign audio_out = audio_q;
   assign busy      = (state_q != IDLE);
   assign overflow  = ovf_q;
   assign dbg_state = state_q;

endmodule
